// File: rtl/pe_pkg.sv
// Shared widths, computation-enable codes and saturation bounds for the PE pipeline.
package pe_pkg;

  localparam int PE_DATA_WIDTH = 16;
  localparam int PE_ACT_NO     = 16;
  localparam int ACT_ADDR_W    = 4;
  localparam int TRUNC_W       = 5;

  typedef enum logic [1:0] {
    COMP_EN_IDLE = 2'b00,
    COMP_EN_ACC  = 2'b01,
    COMP_EN_LOAD = 2'b10,
    COMP_EN_RSVD = 2'b11
  } comp_en_e;

  // Largest and smallest values representable in a w-bit two's-complement word.
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/pe_accum_if.sv
// Product bus from the multiply stage into the add/accumulate stage.
interface pe_accum_if #(
  parameter int W      = 16,
  parameter int ADDR_W = 4,
  parameter int TR_W   = 5
);

  logic [1:0]        comp_en_add;
  logic [ADDR_W-1:0] out_act_addr_add;
  logic [TR_W-1:0]   trunc_amount_add;
  logic [2*W-1:0]    mult_result_add;

  modport master (
    output comp_en_add,
    output out_act_addr_add,
    output trunc_amount_add,
    output mult_result_add
  );

  modport slave (
    input comp_en_add,
    input out_act_addr_add,
    input trunc_amount_add,
    input mult_result_add
  );

endinterface

// File: rtl/pe_accum_sat_trunc.sv
// Arithmetic right shift followed by saturation to a narrower signed width.
module sat_trunc
  import pe_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SH_W  = 5
) (
  input  logic signed [IN_W-1:0]  in_val,
  input  logic        [SH_W-1:0]  shift,
  output logic signed [OUT_W-1:0] out_val,
  output logic                    clip
);

  localparam logic signed [63:0] MAX_V  = sat_max(OUT_W);
  localparam logic signed [63:0] MIN_V  = sat_min(OUT_W);
  localparam int                 MAX_SH = IN_W - 1;

  logic signed [IN_W-1:0] shifted_s;
  logic signed [63:0]     wide_s;

  // Shift (clamped so oversize amounts still give 0 or -1) then clip to OUT_W.
  always_comb begin
    shifted_s = {IN_W{1'b0}};
    wide_s    = 64'sd0;
    out_val   = {OUT_W{1'b0}};
    clip      = 1'b0;
    if (int'(shift) > MAX_SH) begin
      shifted_s = in_val >>> MAX_SH;
    end else begin
      shifted_s = in_val >>> shift;
    end
    wide_s = {{(64-IN_W){shifted_s[IN_W-1]}}, shifted_s};
    if (wide_s > MAX_V) begin
      out_val = MAX_V[OUT_W-1:0];
      clip    = 1'b1;
    end else if (wide_s < MIN_V) begin
      out_val = MIN_V[OUT_W-1:0];
      clip    = 1'b1;
    end else begin
      out_val = wide_s[OUT_W-1:0];
      clip    = 1'b0;
    end
  end

endmodule

// File: rtl/pe_accum.sv
// Add/accumulate stage: truncate+saturate the product, then read-modify-write
// the per-PE accumulator bank, with a registered readout port.
module pe_accum
  import pe_pkg::*;
#(
  parameter int PE_DATA_WIDTH = pe_pkg::PE_DATA_WIDTH,
  parameter int PE_ACT_NO     = pe_pkg::PE_ACT_NO,
  parameter int ACT_ADDR_W    = pe_pkg::ACT_ADDR_W,
  parameter int TRUNC_W       = pe_pkg::TRUNC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pe_accum_if.slave                add_if,
  input  logic                     clear_all,
  input  logic                     rd_en,
  input  logic [ACT_ADDR_W-1:0]    rd_addr,
  output logic [PE_DATA_WIDTH-1:0] rd_data,
  output logic                     rd_valid,
  output logic                     ovf,
  output logic                     busy
);

  localparam int W = PE_DATA_WIDTH;

  comp_en_e            code_s;
  logic                t_op_s;
  logic signed [W-1:0] t_sat_s;
  logic                t_clip_s;

  logic                  t_valid_r;
  comp_en_e              t_code_r;
  logic [ACT_ADDR_W-1:0] t_addr_r;
  logic signed [W-1:0]   t_val_r;

  logic signed [W-1:0] acc_r [PE_ACT_NO];
  logic signed [W-1:0] acc_old_s;
  logic signed [W:0]   sum_s;
  logic signed [W-1:0] sum_sat_s;
  logic                sum_clip_s;

  logic                w_en_s;
  logic signed [W-1:0] w_val_s;
  logic                w_clip_s;

  logic [W-1:0] rd_data_r;
  logic         rd_valid_r;
  logic         ovf_r;

  assign code_s = comp_en_e'(add_if.comp_en_add);

  // Only ACC and LOAD carry work into stage T; IDLE and reserved do not.
  always_comb begin
    t_op_s = 1'b0;
    case (code_s)
      COMP_EN_ACC, COMP_EN_LOAD: t_op_s = 1'b1;
      default:                   t_op_s = 1'b0;
    endcase
  end

  sat_trunc #(
    .IN_W  (2*W),
    .OUT_W (W),
    .SH_W  (TRUNC_W)
  ) u_trunc (
    .in_val  (add_if.mult_result_add),
    .shift   (add_if.trunc_amount_add),
    .out_val (t_sat_s),
    .clip    (t_clip_s)
  );

  // Stage T register: saturated operand with its code and address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_valid_r <= 1'b0;
      t_code_r  <= COMP_EN_IDLE;
      t_addr_r  <= {ACT_ADDR_W{1'b0}};
      t_val_r   <= {W{1'b0}};
    end else begin
      t_valid_r <= t_op_s;
      t_code_r  <= code_s;
      t_addr_r  <= add_if.out_act_addr_add;
      t_val_r   <= t_sat_s;
    end
  end

  // Sum is formed one bit wider so the W-bit saturation sees the true result.
  assign acc_old_s = acc_r[t_addr_r];
  assign sum_s     = {acc_old_s[W-1], acc_old_s} + {t_val_r[W-1], t_val_r};

  sat_trunc #(
    .IN_W  (W+1),
    .OUT_W (W),
    .SH_W  (1)
  ) u_sum_sat (
    .in_val  (sum_s),
    .shift   (1'b0),
    .out_val (sum_sat_s),
    .clip    (sum_clip_s)
  );

  // Stage W write decode; clear_all drops any write landing in its cycle.
  always_comb begin
    w_en_s   = 1'b0;
    w_val_s  = {W{1'b0}};
    w_clip_s = 1'b0;
    if (t_valid_r && !clear_all) begin
      case (t_code_r)
        COMP_EN_LOAD: begin
          w_en_s  = 1'b1;
          w_val_s = t_val_r;
        end
        COMP_EN_ACC: begin
          w_en_s   = 1'b1;
          w_val_s  = sum_sat_s;
          w_clip_s = sum_clip_s;
        end
        default: begin
          w_en_s = 1'b0;
        end
      endcase
    end else begin
      w_en_s = 1'b0;
    end
  end

  // Accumulator bank as flops so clear_all wipes every entry in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PE_ACT_NO; i++) acc_r[i] <= {W{1'b0}};
    end else if (clear_all) begin
      for (int i = 0; i < PE_ACT_NO; i++) acc_r[i] <= {W{1'b0}};
    end else if (w_en_s) begin
      acc_r[t_addr_r] <= w_val_s;
    end
  end

  // Sticky overflow from either saturation point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (clear_all) begin
      ovf_r <= 1'b0;
    end else if ((t_op_s && t_clip_s) || w_clip_s) begin
      ovf_r <= 1'b1;
    end
  end

  // Readout samples the bank before any same-edge write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r  <= {W{1'b0}};
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_en;
      if (rd_en) begin
        rd_data_r <= acc_r[rd_addr];
      end
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign ovf      = ovf_r;
  assign busy     = t_valid_r;

endmodule

// File: tb/tb_pe_accum.sv
// Directed self-checking bench for pe_accum with hand-computed expectations.
module tb_pe_accum;
  import pe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_all = 1'b0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = 4'd0;
  logic [15:0] rd_data;
  logic        rd_valid, ovf, busy;

  int vectors = 0;
  int miscompares = 0;

  pe_accum_if #(.W(16), .ADDR_W(4), .TR_W(5)) bus ();

  pe_accum dut (
    .clk(clk), .rst_n(rst_n), .add_if(bus), .clear_all(clear_all),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic drive_op(input logic [1:0] code, input logic [3:0] addr,
                          input logic [4:0] tr, input logic [31:0] prod);
    bus.comp_en_add = code; bus.out_act_addr_add = addr;
    bus.trunc_amount_add = tr; bus.mult_result_add = prod;
    @(negedge clk);
  endtask

  task automatic drive_idle(input int n);
    bus.comp_en_add = COMP_EN_IDLE;
    bus.mult_result_add = 32'h0;
    repeat (n) @(negedge clk);
  endtask

  task automatic read_entry(input logic [3:0] addr, output logic [15:0] data, output logic valid);
    rd_en = 1'b1; rd_addr = addr;
    @(negedge clk);
    data = rd_data; valid = rd_valid;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d; logic v;
    bus.comp_en_add = COMP_EN_IDLE; bus.out_act_addr_add = 4'd0;
    bus.trunc_amount_add = 5'd0; bus.mult_result_add = 32'h0;
    repeat (2) @(negedge clk);
    vectors++; if ({rd_data, rd_valid, ovf, busy} !== 19'h0) begin miscompares++; $display("FAIL reset_outputs: got %h expected 0", {rd_data, rd_valid, ovf, busy}); end
    rst_n = 1'b1;
    @(negedge clk);
    read_entry(4'd3, d, v);
    vectors++; if (d !== 16'h0000 || v !== 1'b1) begin miscompares++; $display("FAIL reset_acc: got %h/%b expected 0000/1", d, v); end
  endtask

  task automatic test_load();
    logic [15:0] d; logic v;
    drive_op(COMP_EN_LOAD, 4'd3, 5'd8, 32'h00012345);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL load_busy: got %b expected 1", busy); end
    drive_idle(1);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL load_busy_clear: got %b expected 0", busy); end
    read_entry(4'd3, d, v);
    vectors++; if (d !== 16'h0123 || v !== 1'b1) begin miscompares++; $display("FAIL load_value: got %h/%b expected 0123/1", d, v); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL load_ovf: got %b expected 0", ovf); end
  endtask

  task automatic test_trunc_sat();
    logic [15:0] d; logic v;
    drive_op(COMP_EN_LOAD, 4'd10, 5'd0, 32'h00000055);
    drive_op(COMP_EN_LOAD, 4'd1, 5'd0, 32'h7FFF0000);
    drive_op(COMP_EN_LOAD, 4'd4, 5'd1, 32'hFFFFFFFD);
    drive_op(COMP_EN_LOAD, 4'd9, 5'd31, 32'h80000000);
    drive_op(COMP_EN_LOAD, 4'd10, 5'd31, 32'h7FFFFFFF);
    drive_idle(1);
    read_entry(4'd1, d, v);
    vectors++; if (d !== 16'h7FFF) begin miscompares++; $display("FAIL trunc_pos_sat: got %h expected 7fff", d); end
    read_entry(4'd4, d, v);
    vectors++; if (d !== 16'hFFFE) begin miscompares++; $display("FAIL trunc_floor: got %h expected fffe", d); end
    read_entry(4'd9, d, v);
    vectors++; if (d !== 16'hFFFF) begin miscompares++; $display("FAIL trunc_max_neg: got %h expected ffff", d); end
    read_entry(4'd10, d, v);
    vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL trunc_max_pos: got %h expected 0000", d); end
    vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL trunc_ovf: got %b expected 1", ovf); end
  endtask

  task automatic test_clear();
    logic [15:0] d; logic v;
    drive_op(COMP_EN_LOAD, 4'd2, 5'd0, 32'd9);
    drive_op(COMP_EN_ACC, 4'd2, 5'd0, 32'd5);
    // ACC to addr 2 is in stage T; clear, read and a new LOAD all hit this edge.
    clear_all = 1'b1; rd_en = 1'b1; rd_addr = 4'd2;
    bus.comp_en_add = COMP_EN_LOAD; bus.out_act_addr_add = 4'd7;
    bus.trunc_amount_add = 5'd0; bus.mult_result_add = 32'd11;
    @(negedge clk);
    vectors++; if (rd_data !== 16'd9 || rd_valid !== 1'b1) begin miscompares++; $display("FAIL clear_preread: got %h/%b expected 0009/1", rd_data, rd_valid); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL clear_ovf: got %b expected 0", ovf); end
    clear_all = 1'b0; rd_en = 1'b0;
    drive_idle(1);
    read_entry(4'd2, d, v);
    vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL clear_dropped_write: got %h expected 0000", d); end
    read_entry(4'd3, d, v);
    vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL clear_other_entry: got %h expected 0000", d); end
    read_entry(4'd7, d, v);
    vectors++; if (d !== 16'd11) begin miscompares++; $display("FAIL clear_stage_t_kept: got %h expected 000b", d); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d; logic v;
    drive_op(COMP_EN_LOAD, 4'd5, 5'd0, 32'd100);
    drive_op(COMP_EN_ACC, 4'd5, 5'd0, 32'd50);
    drive_op(COMP_EN_ACC, 4'd6, 5'd0, 32'd7);
    drive_op(COMP_EN_ACC, 4'd5, 5'd0, 32'd50);
    drive_op(2'b11, 4'd5, 5'd0, 32'd1000);
    drive_idle(1);
    read_entry(4'd5, d, v);
    vectors++; if (d !== 16'd200) begin miscompares++; $display("FAIL b2b_addr5: got %0d expected 200", d); end
    read_entry(4'd6, d, v);
    vectors++; if (d !== 16'd7) begin miscompares++; $display("FAIL b2b_addr6: got %0d expected 7", d); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL b2b_ovf: got %b expected 0", ovf); end
  endtask

  task automatic test_acc_sat();
    logic [15:0] d; logic v;
    drive_op(COMP_EN_LOAD, 4'd0, 5'd0, 32'd30000);
    drive_op(COMP_EN_ACC, 4'd0, 5'd0, 32'd30000);
    drive_idle(1);
    read_entry(4'd0, d, v);
    vectors++; if (d !== 16'h7FFF || ovf !== 1'b1) begin miscompares++; $display("FAIL acc_pos_sat: got %h/%b expected 7fff/1", d, ovf); end
    clear_all = 1'b1;
    drive_idle(1);
    clear_all = 1'b0;
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL acc_ovf_cleared: got %b expected 0", ovf); end
    drive_op(COMP_EN_LOAD, 4'd0, 5'd0, -32'sd30000);
    drive_op(COMP_EN_ACC, 4'd0, 5'd0, -32'sd30000);
    drive_idle(1);
    read_entry(4'd0, d, v);
    vectors++; if (d !== 16'h8000 || ovf !== 1'b1) begin miscompares++; $display("FAIL acc_neg_sat: got %h/%b expected 8000/1", d, ovf); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d; logic v;
    bus.comp_en_add = COMP_EN_ACC; bus.out_act_addr_add = 4'd8;
    bus.trunc_amount_add = 5'd0; bus.mult_result_add = 32'd10;
    rd_en = 1'b1; rd_addr = 4'd0;
    @(negedge clk);
    bus.comp_en_add = COMP_EN_IDLE; rd_en = 1'b0;
    vectors++; if (busy !== 1'b1 || rd_valid !== 1'b1 || rd_data !== 16'h8000) begin miscompares++; $display("FAIL rstmid_pre: got %b/%b/%h expected 1/1/8000", busy, rd_valid, rd_data); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({rd_data, rd_valid, ovf, busy} !== 19'h0) begin miscompares++; $display("FAIL rstmid_async: got %h expected 0", {rd_data, rd_valid, ovf, busy}); end
    @(negedge clk);
    rst_n = 1'b1;
    drive_op(COMP_EN_ACC, 4'd8, 5'd0, 32'd3);
    drive_idle(1);
    read_entry(4'd8, d, v);
    vectors++; if (d !== 16'd3) begin miscompares++; $display("FAIL rstmid_acc: got %0d expected 3", d); end
    read_entry(4'd0, d, v);
    vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL rstmid_bank: got %h expected 0000", d); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_trunc_sat();
    test_clear();
    test_back_to_back();
    test_acc_sat();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pe_accum.md
# pe_accum

Add/accumulate stage of the PE pipeline and the receiving end of the multiply stage's output interface. Each cycle it takes one registered double-width signed product with its computation-enable code, output-activation address and truncation amount. It arithmetic-shifts and saturates the product to PE data width, then read-modify-writes a per-PE output-activation accumulator bank. A registered readout port drains finished activations to the controller.

## Interface
Parameters:
- PE_DATA_WIDTH, 16, signed activation/weight/accumulator width (W)
- PE_ACT_NO, 16, number of accumulator entries
- ACT_ADDR_W, 4, accumulator address width, `$clog2(PE_ACT_NO)`
- TRUNC_W, 5, truncation-amount width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- comp_en_add  in  2  computation code: 00 IDLE, 01 ACC, 10 LOAD, 11 reserved (treated as IDLE)
- out_act_addr_add  in  ACT_ADDR_W  target accumulator entry
- trunc_amount_add  in  TRUNC_W  right-shift amount, 0..2W-1
- mult_result_add  in  2W  signed product
- clear_all  in  1  synchronous clear of every accumulator and ovf
- rd_en  in  1  readout request
- rd_addr  in  ACT_ADDR_W  readout entry
- rd_data  out  W  readout value
- rd_valid  out  1  rd_data valid this cycle
- ovf  out  1  sticky saturation flag
- busy  out  1  an op is pending in stage T

## Operation
- Stage T, registered: t = mult_result_add >>> trunc_amount_add (arithmetic, floor toward -inf).
  - Saturate t to [-2^(W-1), 2^(W-1)-1].
  - Latch the saturated value with code and address; IDLE/reserved codes latch invalid.
- Stage W, read-modify-write on the registered T contents:
  - LOAD: acc[addr] = T value.
  - ACC: acc[addr] = sat(acc[addr] + T value). The sum is computed at W+1 bits, then saturated to W bits.
- ovf sets when stage T clips or stage W clips. Cleared only by reset or clear_all.
- clear_all: at the edge, all entries and ovf go to 0, and any stage-W write in the same cycle is dropped.
  - Stage T still captures its input normally.
- Readout: rd_data <= acc[rd_addr] at the edge, returning the value before any same-edge write. rd_valid <= rd_en.
  - With rd_en low, rd_data holds its last value.
- No backpressure: one op accepted every cycle.

## Timing
- Reset (rst_n low, asynchronous): all accumulators 0, stage T invalid, rd_data 0, rd_valid 0, ovf 0, busy 0.
- Reset asserted mid-operation discards in-flight ops.
- An op sampled at edge k enters stage T. acc is updated at edge k+1.
- rd_en sampled at edge k+1 returns the old value. rd_en sampled at k+2 or later returns the new value.
- busy = stage T valid. The controller waits for busy low, plus one cycle, before readout.
- Back-to-back ops to the same address need no stall: stage W does a single-cycle read-modify-write.
- Shift amounts ≥ 2W-1 produce 0 or -1 according to sign.

## Structure
- pe_pkg holds:
  - width constants
  - comp_en codes (COMP_EN_IDLE/ACC/LOAD)
  - the saturation bounds function
- One combinational sub-module, sat_trunc (shift + saturate, parameterised input and output width), reused for the stage-W sum saturation with shift 0.
- The accumulator bank is a flop array, not an inferred RAM, so that clear_all completes in one cycle.

## Test plan
- LOAD addr 3, product 0x00012345, trunc 8 → acc[3] = 0x0123 at k+1; rd addr 3 at k+2 → rd_data 0x0123, rd_valid 1, ovf 0.
- LOAD 0x7FFF0000, trunc 0 → value 0x7FFF, ovf 1. Product 0xFFFFFFFD, trunc 1 → -2 (floor).
- Same address 5 on consecutive cycles: LOAD 100, ACC 50, ACC 50 → acc[5] = 200 with no bubble. Interleave with addr 6 ACC 7 → acc[6] = 7.
- LOAD 30000 then ACC 30000 at addr 0 → 32767, ovf 1. Repeat with -30000 → -32768.
- Same cycle: clear_all with a pending ACC to addr 2 → all entries 0 and ovf 0, write dropped. A read of addr 2 in the same cycle returns the pre-clear value.
- rst_n pulsed low between two ACC ops → outputs return to reset values asynchronously. The second op sampled after release accumulates onto 0.
